// File: rtl/audio_codec_config_if.sv
// I2C control-bus signals between the WM8731 configuration sequencer and the board pin logic.
interface audio_codec_config_if;
   logic i2c_sclk;
   logic i2c_sdat_oe;
   logic i2c_sdat_in;

   modport master (output i2c_sclk, output i2c_sdat_oe, input i2c_sdat_in);
   modport slave  (input i2c_sclk, input i2c_sdat_oe, output i2c_sdat_in);
endinterface

// File: rtl/audio_codec_config.sv
// Power-on WM8731 configuration sequencer: writes a 10-entry register table over write-only I2C.
// Optional NACK retry per entry is enabled with the AUDIO_CFG_RETRY_EN macro.
module audio_codec_config #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned I2C_FREQ  = 100000,
   parameter logic [6:0]  DEV_ADDR  = 7'h1A,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   audio_codec_config_if.master        i2c,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [3:0]                  cfg_index
);

   localparam int unsigned Div  = CLK_FREQ / (4 * I2C_FREQ);
   localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

   typedef enum logic [3:0] {
      StIdle, StLoad, StStart, StBit, StAck, StStop, StGap, StFinish, StAbort
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [1:0]        qtr_q, qtr_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        byte_q, byte_d;
   logic [15:0]       word_q, word_d;
   logic [3:0]        idx_q, idx_d;
   logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic              nack_q, nack_d, auto_q, auto_d;
   logic              sda_meta_q, sda_sync_q;
   logic              tick, qtr_end;
   logic [7:0]        cur_byte;
`ifdef AUDIO_CFG_RETRY_EN
   localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RetryW-1:0] retry_q, retry_d;
`endif

   function automatic logic [15:0] cfg_word(input logic [3:0] idx);
      case (idx)
         4'd0:    cfg_word = 16'h1E00;
         4'd1:    cfg_word = 16'h0017;
         4'd2:    cfg_word = 16'h0217;
         4'd3:    cfg_word = 16'h0479;
         4'd4:    cfg_word = 16'h0679;
         4'd5:    cfg_word = 16'h0812;
         4'd6:    cfg_word = 16'h0A00;
         4'd7:    cfg_word = 16'h0C00;
         4'd8:    cfg_word = 16'h0E02;
         4'd9:    cfg_word = 16'h1201;
         default: cfg_word = 16'h0000;
      endcase
   endfunction

   assign tick    = (div_q == DivW'(Div - 1));
   assign qtr_end = tick && (qtr_q == 2'd3);

   always_comb begin
      case (byte_q)
         2'd0:    cur_byte = {DEV_ADDR, 1'b0};
         2'd1:    cur_byte = word_q[15:8];
         default: cur_byte = word_q[7:0];
      endcase
   end

   // Bus levels decode straight from state flops so an async reset releases both lines at once.
   always_comb begin
      i2c.i2c_sclk    = 1'b1;
      i2c.i2c_sdat_oe = 1'b0;
      unique case (state_q)
         StStart: begin
            i2c.i2c_sclk    = ~qtr_q[1];
            i2c.i2c_sdat_oe = 1'b1;
         end
         StBit: begin
            i2c.i2c_sclk    = qtr_q[1];
            i2c.i2c_sdat_oe = ~cur_byte[3'd7 - bit_q];
         end
         StAck:  i2c.i2c_sclk = qtr_q[1];
         StStop: begin
            i2c.i2c_sclk    = (qtr_q != 2'd0);
            i2c.i2c_sdat_oe = ~qtr_q[1];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      word_d  = word_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      nack_d  = nack_q;
      auto_d  = auto_q;
`ifdef AUDIO_CFG_RETRY_EN
      retry_d = retry_q;
`endif
      if (state_q inside {StStart, StBit, StAck, StStop, StGap}) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) qtr_d = qtr_q + 2'd1;
      end
      unique case (state_q)
         StIdle: begin
            // Start arriving in any other state is dropped.
            if (start || auto_q) begin
               auto_d  = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
               retry_d = '0;
`endif
               state_d = StLoad;
            end
         end
         StLoad: begin
            word_d  = cfg_word(idx_q);
            busy_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
            nack_d  = 1'b0;
            div_d   = '0;
            qtr_d   = '0;
            state_d = StStart;
         end
         StStart: begin
            if (qtr_end) begin
               bit_d   = '0;
               byte_d  = '0;
               state_d = StBit;
            end
         end
         StBit: begin
            if (qtr_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = StAck;
            end
         end
         StAck: begin
            if (tick && qtr_q == 2'd2) nack_d = sda_sync_q;
            if (qtr_end) begin
               bit_d = '0;
               if (nack_q || byte_q == 2'd2) begin
                  state_d = StStop;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  state_d = StBit;
               end
            end
         end
         StStop: begin
            if (qtr_end) begin
`ifdef AUDIO_CFG_RETRY_EN
               state_d = (nack_q && retry_q == RetryW'(MAX_RETRY)) ? StAbort : StGap;
`else
               state_d = nack_q ? StAbort : StGap;
`endif
            end
         end
         StGap: begin
            if (qtr_end) begin
`ifdef AUDIO_CFG_RETRY_EN
               if (nack_q) begin
                  retry_d = retry_q + 1'b1;
                  state_d = StLoad;
               end else
`endif
               if (idx_q == 4'd9) begin
                  state_d = StFinish;
               end else begin
                  idx_d   = idx_q + 4'd1;
`ifdef AUDIO_CFG_RETRY_EN
                  retry_d = '0;
`endif
                  state_d = StLoad;
               end
            end
         end
         StFinish: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         StAbort: begin
            busy_d  = 1'b0;
            error_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         div_q      <= '0;
         qtr_q      <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         word_q     <= '0;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         nack_q     <= 1'b0;
         auto_q     <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
`ifdef AUDIO_CFG_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         nack_q     <= nack_d;
         auto_q     <= auto_d;
         sda_meta_q <= i2c.i2c_sdat_in;
         sda_sync_q <= sda_meta_q;
`ifdef AUDIO_CFG_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign cfg_index = idx_q;

endmodule

// File: tb/tb_audio_codec_config.sv
// Directed bench for audio_codec_config: an I2C codec model decodes transactions and ACKs/NACKs.
module tb_audio_codec_config;

   localparam int Div = 10;  // 4 MHz clk, 100 kHz SCL
`ifdef AUDIO_CFG_RETRY_EN
   localparam bit RetryBuild = 1'b1;
`else
   localparam bit RetryBuild = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, error;
   logic [3:0] cfg_index;
   logic       ack_drive = 1'b0;

   audio_codec_config_if bus ();
   assign bus.i2c_sdat_in = ~(bus.i2c_sdat_oe | ack_drive);

   audio_codec_config #(
      .CLK_FREQ (4000000),
      .I2C_FREQ (100000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .i2c       (bus),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .cfg_index (cfg_index)
   );

   initial forever #5 clk = ~clk;

   logic [15:0] exp_word [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                  16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Codec model state
   logic [7:0] q_b0[$], q_b1[$], q_b2[$];
   logic [7:0] cur_b [3];
   logic [7:0] shreg;
   int  attempts [16];
   int  ok_txns, glitches, bitcnt, bytecnt, edge_n, cyc, t_rise, t_fall, hi_len, lo_len;
   int  nack_entry = -1;
   int  nack_budget = 0;  // negative: NACK forever
   bit  in_txn, all_ack, nack_now;
   logic prev_scl = 1'b1, prev_sda = 1'b1, scl, sda;

   task automatic clear_model();
      q_b0.delete(); q_b1.delete(); q_b2.delete();
      foreach (attempts[i]) attempts[i] = 0;
      ok_txns = 0; glitches = 0; in_txn = 0; hi_len = 0; lo_len = 0;
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         scl = bus.i2c_sclk;
         sda = bus.i2c_sdat_in;
         if (prev_scl && scl && prev_sda && !sda) begin
            in_txn = 1; bitcnt = 0; bytecnt = 0; all_ack = 1; edge_n = 0;
            attempts[ok_txns]++;
         end else if (prev_scl && scl && !prev_sda && sda) begin
            if (in_txn && bytecnt == 3 && all_ack) begin
               q_b0.push_back(cur_b[0]); q_b1.push_back(cur_b[1]); q_b2.push_back(cur_b[2]);
               ok_txns++;
            end
            in_txn = 0;
         end else if (prev_scl && scl && prev_sda != sda) begin
            glitches++;
         end else if (in_txn && !prev_scl && scl) begin
            edge_n++;
            if (edge_n == 2) lo_len = cyc - t_fall;
            t_rise = cyc;
            if (bitcnt < 8) begin
               shreg = {shreg[6:0], sda};
               bitcnt++;
            end else begin
               bitcnt = 0;
               if (sda) all_ack = 0;
            end
         end else if (in_txn && prev_scl && !scl) begin
            if (edge_n == 1) hi_len = cyc - t_rise;
            t_fall = cyc;
            if (bitcnt == 8) begin
               nack_now = (bytecnt == 0 && ok_txns == nack_entry && nack_budget != 0);
               if (nack_now && nack_budget > 0) nack_budget--;
               ack_drive = !nack_now;
               if (bytecnt < 3) cur_b[bytecnt] = shreg;
               bytecnt++;
            end else begin
               ack_drive = 1'b0;
            end
         end
         prev_scl = scl;
         prev_sda = sda;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int lim);
      int n = 0;
      while (!(!busy && (done || error)) && n < lim) begin
         @(negedge clk);
         n++;
      end
      check(tag, n < lim, 1'b1);
   endtask

   task automatic wait_txns(input string tag, input int k, input int lim);
      int n = 0;
      while (ok_txns < k && n < lim) begin
         @(negedge clk);
         n++;
      end
      check(tag, n < lim, 1'b1);
   endtask

   initial begin
      int n;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_sclk", bus.i2c_sclk, 1);
      check("rst_oe", bus.i2c_sdat_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_index", cfg_index, 0);

      // Full table after reset release, every byte ACKed
      reset_n = 1'b1;
      @(negedge clk);
      check("auto_start", busy, 1);
      wait_end("run1_timeout", 20000);
      check("run1_txns", q_b0.size(), 10);
      for (int i = 0; i < 10 && i < q_b0.size(); i++) begin
         check($sformatf("run1_addr%0d", i), q_b0[i], 8'h34);
         check($sformatf("run1_word%0d", i), {q_b1[i], q_b2[i]}, exp_word[i]);
      end
      check("run1_done", done, 1);
      check("run1_busy", busy, 0);
      check("run1_error", error, 0);
      check("run1_index", cfg_index, 9);
      check("scl_high_len", hi_len, 2 * Div);
      check("scl_low_len", lo_len, 2 * Div);
      check("sda_glitches", glitches, 0);

      // Restart from done, with a start pulse ignored mid-sequence
      clear_model();
      pulse_start();
      check("done_clr", done, 0);
      check("busy_set", busy, 1);
      wait_txns("run2_first_timeout", 1, 3000);
      check("run2_first_hi", (q_b1.size() > 0) ? q_b1[0] : 8'hxx, 8'h1E);
      n = 0;
      while (cfg_index != 4'd5 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("run2_idx5_timeout", n < 20000, 1'b1);
      pulse_start();
      wait_end("run2_timeout", 20000);
      check("run2_txns", ok_txns, 10);
      check("run2_entry0_tries", attempts[0], 1);
      check("run2_entry5_tries", attempts[5], 1);
      check("run2_done", done, 1);
      check("run2_index", cfg_index, 9);

      // Asynchronous reset in the middle of entry 2
      clear_model();
      pulse_start();
      n = 0;
      while (!(ok_txns == 2 && in_txn && bytecnt == 1 && bitcnt == 4) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("midrst_timeout", n < 20000, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_sclk", bus.i2c_sclk, 1);
      check("midrst_oe", bus.i2c_sdat_oe, 0);
      check("midrst_busy", busy, 0);
      repeat (3) @(negedge clk);
      clear_model();
      reset_n = 1'b1;
      wait_txns("midrst_first_timeout", 1, 3000);
      check("midrst_restart_word", (q_b1.size() > 0) ? {q_b1[0], q_b2[0]} : 16'hxxxx, 16'h1E00);

      // Entry 3 NACKs every address byte
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      clear_model();
      nack_entry  = 3;
      nack_budget = -1;
      reset_n = 1'b1;
      @(negedge clk);
      wait_end("nack_timeout", 20000);
      check("nack_tries", attempts[3], RetryBuild ? 4 : 1);
      check("nack_ok_txns", ok_txns, 3);
      check("nack_error", error, 1);
      check("nack_done", done, 0);
      check("nack_index", cfg_index, 3);
      check("nack_busy", busy, 0);
      check("nack_sclk", bus.i2c_sclk, 1);
      check("nack_oe", bus.i2c_sdat_oe, 0);

      // A single NACK on entry 3
      clear_model();
      nack_budget = 1;
      pulse_start();
      check("err_clr", error, 0);
      wait_end("nack1_timeout", 20000);
      check("nack1_tries", attempts[3], RetryBuild ? 2 : 1);
      check("nack1_ok_txns", ok_txns, RetryBuild ? 10 : 3);
      check("nack1_done", done, RetryBuild ? 1 : 0);
      check("nack1_error", error, RetryBuild ? 0 : 1);
      check("nack1_index", cfg_index, RetryBuild ? 9 : 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/audio_codec_config.md
Name: audio_codec_config

Overview:
- Power-on configuration sequencer for the on-board WM8731 audio codec, used in builds with USE_AUDIO.
- After reset it walks an internal 10-entry register table and writes each entry over a write-only I2C master (device address 0x1A).
- It reports busy, done and error status to the audio peripheral and to the LEDs.
- It owns the codec control bus exclusively; the board top converts the SDA output-enable into the open-drain pin.

Parameters:
- CLK_FREQ, 50000000: clk frequency in Hz.
- I2C_FREQ, 100000: SCL frequency in Hz.
- DEV_ADDR, 7'h1A: codec 7-bit I2C address.
- MAX_RETRY, 3: NACK retries per table entry. Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; re-runs the whole table.
- i2c_sclk  out  1  SCL, push-pull (codec never stretches the clock).
- i2c_sdat_oe  out  1  1 = drive SDA low; 0 = release SDA.
- i2c_sdat_in  in  1  sampled SDA pin level.
- busy  out  1  table sequence in progress.
- done  out  1  all entries ACKed; sticky until the next start or reset.
- error  out  1  sequence aborted on NACK; sticky until the next start or reset.
- cfg_index  out  4  index of the current entry, or of the failing entry after an abort.

Behaviour:
- Reset values: i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, error=0, cfg_index=0, all counters 0.
- Reset is asynchronous. Asserting it mid-transfer releases both lines immediately; no STOP is generated.
- Auto-start: the first clk edge after reset_n deasserts acts as a start.
- Tick generator: one tick every DIV = CLK_FREQ/(4*I2C_FREQ) clk cycles (125 at the defaults). Each bit is 4 quarters: q0, q1, q2, q3.
- Bit timing:
  - q0: SCL low; SDA updated at the start of q0.
  - q1: SCL low.
  - q2: SCL high; SDA sampled on the last clk of q2.
  - q3: SCL high.
- Bit period = 4*DIV clk cycles (500 at the defaults).
- Table: 16-bit word = {reg[6:0], data[8:0]}.
  - Entry 0: 0x1E00 (reset)
  - Entry 1: 0x0017 (L line in)
  - Entry 2: 0x0217 (R line in)
  - Entry 3: 0x0479 (L headphone)
  - Entry 4: 0x0679 (R headphone)
  - Entry 5: 0x0812 (analog path, DAC select)
  - Entry 6: 0x0A00 (digital path)
  - Entry 7: 0x0C00 (power, all on)
  - Entry 8: 0x0E02 (I2S, 16-bit, slave)
  - Entry 9: 0x1201 (active)
- Each transaction sends, MSB first: START, {DEV_ADDR,0}=0x34, ACK, word[15:8], ACK, word[7:0], ACK, STOP.
- States and transitions:
  - IDLE: lines released. start → LOAD.
  - LOAD: fetch table[cfg_index]; busy=1; clear done and error → START.
  - START: SDA low while SCL high for 2 quarters, then SCL low for 2 quarters → BIT.
  - BIT: 8 bits of the current byte → ACK.
  - ACK: SDA released; sample at end of q2. Sampled 0 with more bytes → BIT. Sampled 0 after the last byte → STOP. Sampled 1 → NACK handling.
  - STOP: q0 SCL low/SDA low; q1 SCL high; q2 SDA released; q3 idle. Then GAP.
  - GAP: 4 quarters with the bus free. cfg_index<9: increment cfg_index → LOAD. cfg_index=9 → FINISH.
  - FINISH: busy=0, done=1 → IDLE.
- NACK handling (feature disabled): after the NACK, STOP → ABORT.
- ABORT: busy=0, error=1; cfg_index holds the failing entry → IDLE.
- start while busy=1: ignored. A start in the same cycle the sequence finishes is also ignored.
- start from IDLE: cfg_index=0 and the whole table is re-run.
- i2c_sdat_in is passed through a 2-flop synchronizer before sampling.

Optional Feature:
- Macro: AUDIO_CFG_RETRY_EN.
- Defined: on NACK, send STOP and GAP, then resend the same entry from START. Up to MAX_RETRY retries per entry; the retry counter clears on each new entry. A NACK on retry MAX_RETRY → ABORT.
- Undefined: the first NACK → STOP → ABORT. The retry counter logic is absent.

Test Plan:
- Reset release, codec model ACKs everything → 10 transactions decoded.
  - First transaction bytes: 0x34, 0x1E, 0x00. Last: 0x34, 0x12, 0x01.
  - done=1, busy=0, error=0, cfg_index=9.
- SCL timing → high and low phases each 250 clk. START is SDA falling while SCL=1. STOP is SDA rising while SCL=1. SDA never changes while SCL=1 otherwise.
- Model NACKs every address byte of entry 3, macro undefined → exactly 1 attempt at entry 3, then error=1, cfg_index=3, busy=0, lines released.
- Same NACK, AUDIO_CFG_RETRY_EN defined → entry 3 sent 4 times total, then error=1, cfg_index=3. Second run with a single NACK → recovers, done=1.
- start pulsed while busy at entry 5 → sequence unaffected. start after done → done clears next cycle, entry 0 is resent.
- reset_n low during bit 4 of entry 2 → same cycle: i2c_sclk=1, i2c_sdat_oe=0, busy=0. After release → restarts at entry 0.
